// File: rtl/hazard_pipe_tracker_if.sv
// Hazard-unit <-> pipeline tracker bundle: decode-side commands and fields in, stage-tagged
// control signals and profiling counters out.
interface hazard_pipe_tracker_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic             BranchTakenE;
  logic             CondExE;
  logic [REG_W-1:0] RA1D;
  logic [REG_W-1:0] RA2D;
  logic [REG_W-1:0] WA3D;
  logic             RegWriteD;
  logic             MemToRegD;
  logic             PCSrcD;
  logic             CntClr;

  logic             ValidD;
  logic             ValidE;
  logic             ValidM;
  logic             ValidW;
  logic [REG_W-1:0] RA1E;
  logic [REG_W-1:0] RA2E;
  logic [REG_W-1:0] WA3E;
  logic [REG_W-1:0] WA3M;
  logic [REG_W-1:0] WA3W;
  logic             RegWriteE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             MemToRegE;
  logic             MemToRegM;
  logic             MemToRegW;
  logic             PCSrcE;
  logic             PCSrcM;
  logic             PCSrcW;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] RetireCount;

  modport master (
    output StallD, FlushD, FlushE, BranchTakenE, CondExE, RA1D, RA2D, WA3D,
           RegWriteD, MemToRegD, PCSrcD, CntClr,
    input  ValidD, ValidE, ValidM, ValidW, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, MemToRegW,
           PCSrcE, PCSrcM, PCSrcW, StallCount, BranchCount, RetireCount
  );

  modport slave (
    input  StallD, FlushD, FlushE, BranchTakenE, CondExE, RA1D, RA2D, WA3D,
           RegWriteD, MemToRegD, PCSrcD, CntClr,
    output ValidD, ValidE, ValidM, ValidW, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, MemToRegW,
           PCSrcE, PCSrcM, PCSrcW, StallCount, BranchCount, RetireCount
  );
endinterface

// File: rtl/hazard_pipe_tracker.sv
// Carries per-instruction register addresses and control bits through D/E/M/W under hazard-unit
// stall/flush control, plus saturating stall, taken-branch and retire counters.
module hazard_pipe_tracker #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input logic                 CLK,
  input logic                 Reset,
  hazard_pipe_tracker_if.slave hz
);

  logic             valid_d_q, valid_d_d;
  logic             valid_e_q, valid_e_d;
  logic [REG_W-1:0] ra1_e_q, ra1_e_d;
  logic [REG_W-1:0] ra2_e_q, ra2_e_d;
  logic [REG_W-1:0] wa3_e_q, wa3_e_d;
  logic             reg_write_e_q, reg_write_e_d;
  logic             mem_to_reg_e_q, mem_to_reg_e_d;
  logic             pc_src_e_q, pc_src_e_d;

  logic             valid_m_q, valid_m_d;
  logic [REG_W-1:0] wa3_m_q, wa3_m_d;
  logic             reg_write_m_q, reg_write_m_d;
  logic             mem_to_reg_m_q, mem_to_reg_m_d;
  logic             pc_src_m_q, pc_src_m_d;

  logic             valid_w_q;
  logic [REG_W-1:0] wa3_w_q;
  logic             reg_write_w_q;
  logic             mem_to_reg_w_q;
  logic             pc_src_w_q;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic             bubble_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_comb begin
    valid_d_d = valid_d_q;
    if (hz.FlushD) begin
      valid_d_d = 1'b0;
    end else if (!hz.StallD) begin
      valid_d_d = 1'b1;
    end
  end

  // A held decode slot must not also advance into Execute, so a stall forces a bubble there.
  assign bubble_e = hz.FlushE | hz.StallD;

  always_comb begin
    valid_e_d      = 1'b0;
    ra1_e_d        = '0;
    ra2_e_d        = '0;
    wa3_e_d        = '0;
    reg_write_e_d  = 1'b0;
    mem_to_reg_e_d = 1'b0;
    pc_src_e_d     = 1'b0;
    if (!bubble_e) begin
      valid_e_d      = valid_d_q;
      ra1_e_d        = hz.RA1D;
      ra2_e_d        = hz.RA2D;
      wa3_e_d        = hz.WA3D;
      reg_write_e_d  = hz.RegWriteD & valid_d_q;
      mem_to_reg_e_d = hz.MemToRegD & valid_d_q;
      pc_src_e_d     = hz.PCSrcD & valid_d_q;
    end
  end

  // A condition-failed instruction keeps its address; only its side effects are dropped.
  always_comb begin
    valid_m_d      = valid_e_q;
    wa3_m_d        = wa3_e_q;
    mem_to_reg_m_d = mem_to_reg_e_q;
    reg_write_m_d  = reg_write_e_q & hz.CondExE;
    pc_src_m_d     = pc_src_e_q & hz.CondExE;
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    branch_cnt_d = branch_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (hz.CntClr) begin
      stall_cnt_d  = '0;
      branch_cnt_d = '0;
      retire_cnt_d = '0;
    end else begin
      if (hz.StallD)       stall_cnt_d  = sat_inc(stall_cnt_q);
      if (hz.BranchTakenE) branch_cnt_d = sat_inc(branch_cnt_q);
      if (valid_w_q)       retire_cnt_d = sat_inc(retire_cnt_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      valid_d_q      <= 1'b0;
      valid_e_q      <= 1'b0;
      ra1_e_q        <= '0;
      ra2_e_q        <= '0;
      wa3_e_q        <= '0;
      reg_write_e_q  <= 1'b0;
      mem_to_reg_e_q <= 1'b0;
      pc_src_e_q     <= 1'b0;
      valid_m_q      <= 1'b0;
      wa3_m_q        <= '0;
      reg_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      pc_src_m_q     <= 1'b0;
      valid_w_q      <= 1'b0;
      wa3_w_q        <= '0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      pc_src_w_q     <= 1'b0;
      stall_cnt_q    <= '0;
      branch_cnt_q   <= '0;
      retire_cnt_q   <= '0;
    end else begin
      valid_d_q      <= valid_d_d;
      valid_e_q      <= valid_e_d;
      ra1_e_q        <= ra1_e_d;
      ra2_e_q        <= ra2_e_d;
      wa3_e_q        <= wa3_e_d;
      reg_write_e_q  <= reg_write_e_d;
      mem_to_reg_e_q <= mem_to_reg_e_d;
      pc_src_e_q     <= pc_src_e_d;
      valid_m_q      <= valid_m_d;
      wa3_m_q        <= wa3_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
      pc_src_m_q     <= pc_src_m_d;
      valid_w_q      <= valid_m_q;
      wa3_w_q        <= wa3_m_q;
      reg_write_w_q  <= reg_write_m_q;
      mem_to_reg_w_q <= mem_to_reg_m_q;
      pc_src_w_q     <= pc_src_m_q;
      stall_cnt_q    <= stall_cnt_d;
      branch_cnt_q   <= branch_cnt_d;
      retire_cnt_q   <= retire_cnt_d;
    end
  end

  assign hz.ValidD      = valid_d_q;
  assign hz.ValidE      = valid_e_q;
  assign hz.ValidM      = valid_m_q;
  assign hz.ValidW      = valid_w_q;
  assign hz.RA1E        = ra1_e_q;
  assign hz.RA2E        = ra2_e_q;
  assign hz.WA3E        = wa3_e_q;
  assign hz.WA3M        = wa3_m_q;
  assign hz.WA3W        = wa3_w_q;
  assign hz.RegWriteE   = reg_write_e_q;
  assign hz.RegWriteM   = reg_write_m_q;
  assign hz.RegWriteW   = reg_write_w_q;
  assign hz.MemToRegE   = mem_to_reg_e_q;
  assign hz.MemToRegM   = mem_to_reg_m_q;
  assign hz.MemToRegW   = mem_to_reg_w_q;
  assign hz.PCSrcE      = pc_src_e_q;
  assign hz.PCSrcM      = pc_src_m_q;
  assign hz.PCSrcW      = pc_src_w_q;
  assign hz.StallCount  = stall_cnt_q;
  assign hz.BranchCount = branch_cnt_q;
  assign hz.RetireCount = retire_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Directed bench for hazard_pipe_tracker: stimulus queues cycle-tagged expectations, a negedge
// monitor pops and compares them; a second narrow-counter instance covers saturation.
module tb_hazard_pipe_tracker;

  logic CLK = 1'b0;
  logic Reset;
  logic rst_s;

  always #5 CLK = ~CLK;

  hazard_pipe_tracker_if #(.REG_W(5), .CNT_W(32)) m_if ();
  hazard_pipe_tracker_if #(.REG_W(5), .CNT_W(4))  s_if ();

  hazard_pipe_tracker #(.REG_W(5), .CNT_W(32)) u_dut (
    .CLK   (CLK),
    .Reset (Reset),
    .hz    (m_if)
  );

  hazard_pipe_tracker #(.REG_W(5), .CNT_W(4)) u_dut_sat (
    .CLK   (CLK),
    .Reset (rst_s),
    .hz    (s_if)
  );

  typedef enum int {
    SelValidD, SelValidE, SelValidM, SelValidW, SelRA1E, SelRA2E, SelWA3E, SelWA3M, SelWA3W,
    SelRegWriteE, SelRegWriteM, SelRegWriteW, SelMemToRegE, SelMemToRegM, SelMemToRegW,
    SelPCSrcE, SelPCSrcM, SelStallCount, SelBranchCount, SelRetireCount, SelSatStallCount
  } sel_e;

  typedef struct {
    int unsigned cyc;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          passed = 0;
  int          total = 0;
  bit          done = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] get(input sel_e s);
    case (s)
      SelValidD:        return 32'(m_if.ValidD);
      SelValidE:        return 32'(m_if.ValidE);
      SelValidM:        return 32'(m_if.ValidM);
      SelValidW:        return 32'(m_if.ValidW);
      SelRA1E:          return 32'(m_if.RA1E);
      SelRA2E:          return 32'(m_if.RA2E);
      SelWA3E:          return 32'(m_if.WA3E);
      SelWA3M:          return 32'(m_if.WA3M);
      SelWA3W:          return 32'(m_if.WA3W);
      SelRegWriteE:     return 32'(m_if.RegWriteE);
      SelRegWriteM:     return 32'(m_if.RegWriteM);
      SelRegWriteW:     return 32'(m_if.RegWriteW);
      SelMemToRegE:     return 32'(m_if.MemToRegE);
      SelMemToRegM:     return 32'(m_if.MemToRegM);
      SelMemToRegW:     return 32'(m_if.MemToRegW);
      SelPCSrcE:        return 32'(m_if.PCSrcE);
      SelPCSrcM:        return 32'(m_if.PCSrcM);
      SelStallCount:    return m_if.StallCount;
      SelBranchCount:   return m_if.BranchCount;
      SelRetireCount:   return m_if.RetireCount;
      SelSatStallCount: return 32'(s_if.StallCount);
      default:          return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: compare every expectation tagged for the edge just taken; unmet ones fail at the end.
  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        total++;
        if (get(sb[i].sel) === sb[i].val) begin
          passed++;
        end else begin
          $display("FAIL %s edge=%0d actual=%0d required=%0d", sb[i].sel.name(), cyc,
                   get(sb[i].sel), sb[i].val);
        end
        sb.delete(i);
      end else if (done) begin
        total++;
        $display("FAIL %s edge=%0d actual=never_checked required=%0d", sb[i].sel.name(),
                 sb[i].cyc, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic exp_at(input int unsigned k, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + k;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_main();
    m_if.StallD = 0; m_if.FlushD = 0; m_if.FlushE = 0; m_if.BranchTakenE = 0;
    m_if.CondExE = 1; m_if.RA1D = 0; m_if.RA2D = 0; m_if.WA3D = 0;
    m_if.RegWriteD = 0; m_if.MemToRegD = 0; m_if.PCSrcD = 0; m_if.CntClr = 0;
  endtask

  initial begin
    // Reset held with every input active.
    Reset = 0; rst_s = 0;
    m_if.StallD = 1; m_if.FlushD = 1; m_if.FlushE = 1; m_if.BranchTakenE = 1;
    m_if.CondExE = 1; m_if.RA1D = 31; m_if.RA2D = 30; m_if.WA3D = 29;
    m_if.RegWriteD = 1; m_if.MemToRegD = 1; m_if.PCSrcD = 1; m_if.CntClr = 1;
    s_if.StallD = 0; s_if.FlushD = 0; s_if.FlushE = 0; s_if.BranchTakenE = 0;
    s_if.CondExE = 0; s_if.RA1D = 0; s_if.RA2D = 0; s_if.WA3D = 0;
    s_if.RegWriteD = 0; s_if.MemToRegD = 0; s_if.PCSrcD = 0; s_if.CntClr = 0;
    exp_at(3, SelValidD, 0); exp_at(3, SelValidE, 0); exp_at(3, SelWA3E, 0);
    exp_at(3, SelRegWriteE, 0); exp_at(3, SelValidW, 0); exp_at(3, SelStallCount, 0);
    exp_at(3, SelBranchCount, 0);
    tick(); tick(); tick();

    // Release: decode fills on the first edge, Execute still empty.
    Reset = 1; idle_main();
    exp_at(1, SelValidD, 1); exp_at(1, SelValidE, 0);
    tick();

    // One instruction flowing D -> E -> M -> W.
    m_if.RA1D = 3; m_if.RA2D = 4; m_if.WA3D = 5; m_if.RegWriteD = 1;
    exp_at(1, SelRA1E, 3); exp_at(1, SelRA2E, 4); exp_at(1, SelWA3E, 5);
    exp_at(1, SelRegWriteE, 1); exp_at(1, SelValidE, 1);
    exp_at(2, SelWA3M, 5); exp_at(2, SelRegWriteM, 1);
    exp_at(3, SelWA3W, 5); exp_at(3, SelRegWriteW, 1); exp_at(3, SelValidW, 1);
    exp_at(3, SelRetireCount, 0); exp_at(4, SelRetireCount, 1);
    tick();
    idle_main();
    tick(); tick(); tick();

    // Load-use: load sits in E, then stall+flush.
    m_if.WA3D = 7; m_if.MemToRegD = 1; m_if.RegWriteD = 1;
    exp_at(1, SelWA3E, 7); exp_at(1, SelMemToRegE, 1);
    tick();
    m_if.StallD = 1; m_if.FlushE = 1; m_if.WA3D = 8; m_if.MemToRegD = 0;
    exp_at(1, SelValidD, 1); exp_at(1, SelWA3E, 0); exp_at(1, SelRegWriteE, 0);
    exp_at(1, SelValidE, 0); exp_at(1, SelStallCount, 1);
    exp_at(1, SelWA3M, 7); exp_at(1, SelMemToRegM, 1);
    tick();
    m_if.StallD = 0; m_if.FlushE = 0;
    exp_at(1, SelWA3E, 8); exp_at(1, SelValidE, 1); exp_at(1, SelValidM, 0);
    exp_at(1, SelStallCount, 1); exp_at(1, SelWA3W, 7); exp_at(1, SelMemToRegW, 1);
    tick();

    // Condition fail in Execute.
    m_if.WA3D = 9; m_if.RegWriteD = 1; m_if.PCSrcD = 1;
    exp_at(1, SelPCSrcE, 1); exp_at(1, SelRegWriteE, 1);
    tick();
    idle_main(); m_if.CondExE = 0;
    exp_at(1, SelRegWriteM, 0); exp_at(1, SelPCSrcM, 0); exp_at(1, SelWA3M, 9);
    exp_at(1, SelValidM, 1);
    tick();

    // FlushD+StallD+FlushE together, with a taken branch.
    idle_main();
    m_if.FlushD = 1; m_if.StallD = 1; m_if.FlushE = 1; m_if.BranchTakenE = 1;
    exp_at(1, SelValidD, 0); exp_at(1, SelValidE, 0); exp_at(1, SelBranchCount, 1);
    exp_at(1, SelStallCount, 2);
    tick();
    idle_main();
    exp_at(1, SelValidD, 1); exp_at(1, SelValidE, 0); exp_at(1, SelBranchCount, 1);
    tick();

    // CntClr wins over simultaneous increments.
    m_if.StallD = 1; m_if.CntClr = 1; m_if.BranchTakenE = 1;
    exp_at(1, SelStallCount, 0); exp_at(1, SelBranchCount, 0); exp_at(1, SelRetireCount, 0);
    exp_at(1, SelValidD, 1);
    tick();
    idle_main(); m_if.BranchTakenE = 1;
    exp_at(1, SelBranchCount, 1);
    tick();

    // Reset mid-operation discards everything.
    Reset = 0;
    exp_at(1, SelValidD, 0); exp_at(1, SelValidE, 0); exp_at(1, SelValidW, 0);
    exp_at(1, SelWA3M, 0); exp_at(1, SelBranchCount, 0); exp_at(1, SelRetireCount, 0);
    tick();
    Reset = 1; idle_main();

    // Narrow counter saturates at 15, then clears.
    rst_s = 1; s_if.StallD = 1;
    exp_at(14, SelSatStallCount, 14); exp_at(15, SelSatStallCount, 15);
    exp_at(20, SelSatStallCount, 15);
    for (int i = 0; i < 20; i++) tick();
    s_if.CntClr = 1;
    exp_at(1, SelSatStallCount, 0);
    tick();
    s_if.CntClr = 0;
    exp_at(1, SelSatStallCount, 1);
    tick();
    s_if.StallD = 0;

    tick(); tick();
    done = 1'b1;
    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
